// File: rtl/mnist_pkg.sv
// Shared constants and loader FSM encoding for the MNIST front end.
// Contents:
//   NUM_PIXELS, PIXEL_W, ADDR_W : frame geometry (28x28 pixels, 16-bit fixed point)
//   loader_state_t + St* consts : image_stream_loader FSM encoding
//   is_loading()                : states in which the byte stream is accepted
package mnist_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIXEL_W    = 16;
  localparam int unsigned ADDR_W     = 10;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t StLoadLo  = 3'd0;
  localparam loader_state_t StLoadHi  = 3'd1;
  localparam loader_state_t StCksum   = 3'd2;
  localparam loader_state_t StStart   = 3'd3;
  localparam loader_state_t StWaitNet = 3'd4;

  function automatic logic is_loading(input loader_state_t st);
    return (st == StLoadLo) || (st == StLoadHi) || (st == StCksum);
  endfunction

endpackage

// File: rtl/image_stream_loader_if.sv
// Byte-stream handshake feeding image_stream_loader.
//   s_valid : byte present (master -> slave)
//   s_data  : byte value   (master -> slave)
//   s_ready : byte taken when s_valid && s_ready (slave -> master)
interface image_stream_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/pixel_buffer_ram.sv
// 1W/1R synchronous pixel RAM, read-before-write, registered read data.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears only the read register)
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : read address; addresses >= Depth read as 0
//   rdata_o   : mem[raddr_i] one cycle later
module pixel_buffer_ram #(
  parameter int unsigned Depth = 784,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Separate read process: non-blocking update gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (raddr_i <= LastAddr) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_stream_loader.sv
// Writable image buffer for the 784-128-32-10 MNIST network. Packs little-endian byte pairs
// from a byte stream into 16-bit pixels, stores one frame, pulses net_start_o, then refuses
// bytes until net_done_i. Pixels are read back by address with one cycle of latency.
// Build option: define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   strm_io        : byte stream (slave side)
//   rd_addr_i      : pixel read address
//   rd_data_o      : registered pixel at rd_addr_i (0 beyond the frame)
//   net_start_o    : one-cycle pulse when a frame is complete
//   net_done_i     : network finished; releases the buffer for the next frame
//   frame_busy_o   : high while the network owns the frame
//   frame_count_o  : number of frames started (wraps)
//   cksum_err_o    : sticky checksum failure (0 when the checksum option is off)
module image_stream_loader
  import mnist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  image_stream_loader_if.slave strm_io,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [PIXEL_W-1:0]   rd_data_o,
  output logic                 net_start_o,
  input  logic                 net_done_i,
  output logic                 frame_busy_o,
  output logic [15:0]          frame_count_o,
  output logic                 cksum_err_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [7:0]          lo_q, lo_d;
  logic                busy_q, busy_d;
  logic [15:0]         count_q, count_d;
  logic                s_ready_q, s_ready_d;
  logic                accept;
  logic                we;
  logic [PIXEL_W-1:0]  wdata;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
  logic                err_q, err_d;
`endif

  assign accept = strm_io.s_valid && s_ready_q;
  assign wdata  = {strm_io.s_data, lo_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    count_d = count_q;
    we      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    xor_d   = xor_q;
    err_d   = err_q;
`endif
    case (state_q)
      StLoadLo: begin
        if (accept) begin
          lo_d    = strm_io.s_data;
          state_d = StLoadHi;
`ifdef FRAME_CHECKSUM_EN
          xor_d   = xor_q ^ strm_io.s_data;
`endif
        end
      end
      StLoadHi: begin
        if (accept) begin
          we = 1'b1;
`ifdef FRAME_CHECKSUM_EN
          xor_d = xor_q ^ strm_io.s_data;
`endif
          if (idx_q == LastIdx) begin
            idx_d   = '0;
`ifdef FRAME_CHECKSUM_EN
            state_d = StCksum;
`else
            state_d = StStart;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StLoadLo;
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      StCksum: begin
        if (accept) begin
          xor_d = '0;  // fresh accumulator for the next frame either way
          if (strm_io.s_data == xor_q) begin
            state_d = StStart;
          end else begin
            err_d   = 1'b1;
            state_d = StLoadLo;
          end
        end
      end
`endif
      StStart: begin
        count_d = count_q + 16'd1;
        busy_d  = 1'b1;
        state_d = StWaitNet;
      end
      StWaitNet: begin
        if (net_done_i) begin
          busy_d  = 1'b0;
          state_d = StLoadLo;
        end
      end
      default: state_d = StLoadLo;
    endcase
    // Registered ready tracks the state we are about to enter.
    s_ready_d = is_loading(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoadLo;
      idx_q     <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      xor_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
`ifdef FRAME_CHECKSUM_EN
      xor_q     <= xor_d;
      err_q     <= err_d;
`endif
    end
  end

  pixel_buffer_ram #(
    .Depth (NUM_PIXELS),
    .Width (PIXEL_W),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (wdata),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_data_o)
  );

  assign strm_io.s_ready = s_ready_q;
  assign net_start_o     = (state_q == StStart);
  assign frame_busy_o    = busy_q;
  assign frame_count_o   = count_q;
`ifdef FRAME_CHECKSUM_EN
  assign cksum_err_o     = err_q;
`else
  assign cksum_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader with a pixel scoreboard.
// Define FRAME_CHECKSUM_EN for both bench and RTL to exercise the checksum option.
module tb_image_stream_loader;

`ifdef FRAME_CHECKSUM_EN
  localparam int FrameBytes = 1569;
`else
  localparam int FrameBytes = 1568;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        net_start;
  logic        net_done;
  logic        frame_busy;
  logic [15:0] frame_count;
  logic        cksum_err;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int st_cnt = 0;
  logic [15:0] exp_q[$];

  image_stream_loader_if strm ();

  image_stream_loader dut (
    .clk           (clk),
    .rst           (rst),
    .strm_io       (strm),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .net_start_o   (net_start),
    .net_done_i    (net_done),
    .frame_busy_o  (frame_busy),
    .frame_count_o (frame_count),
    .cksum_err_o   (cksum_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (strm.s_valid && strm.s_ready) hs_cnt <= hs_cnt + 1;
    if (net_start) st_cnt <= st_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; s_ready is registered so it is stable here.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    strm.s_valid = 1'b1;
    strm.s_data  = b;
    while (strm.s_ready !== 1'b1 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check("ready_timeout", 32'(t), 32'(0));
    @(posedge clk); #1;
    strm.s_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit rand_gaps, input bit bad_ck);
    logic [15:0] p;
    logic [7:0]  x = 8'h00;
    for (int i = 0; i < 784; i++) begin
      p = (kind == 0) ? 16'(i) : 16'hABCD;
      send_byte(p[7:0],  rand_gaps ? int'($urandom_range(0, 1)) : 0);
      send_byte(p[15:8], rand_gaps ? int'($urandom_range(0, 1)) : 0);
      x = x ^ p[7:0] ^ p[15:8];
      exp_q.push_back(p);
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte(bad_ck ? (x ^ 8'h01) : x, 0);
`else
    if (bad_ck) x = ~x;
`endif
  endtask

  task automatic read_pix(input logic [9:0] a, output logic [15:0] d);
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic check_frame(input string tag);
    logic [15:0] d;
    for (int a = 0; a < 784; a++) begin
      read_pix(10'(a), d);
      check(tag, {16'h0, d}, {16'h0, exp_q.pop_front()});
    end
  endtask

  task automatic pulse_net_done();
    net_done = 1'b1;
    @(posedge clk); #1;
    net_done = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int hs0, st0;
    logic [15:0] d;
    rst          = 1'b1;
    strm.s_valid = 1'b0;
    strm.s_data  = 8'h00;
    rd_addr      = '0;
    net_done     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(strm.s_ready), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_net_start", 32'(net_start), 32'(0));
    check("rst_busy", 32'(frame_busy), 32'(0));
    check("rst_count", 32'(frame_count), 32'(0));
    check("rst_cksum_err", 32'(cksum_err), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(strm.s_ready), 32'(1));

    // Case 1: pixel i = i, no gaps.
    hs0 = hs_cnt; st0 = st_cnt;
    send_frame(0, 1'b0, 1'b0);
    check("c1_net_start", 32'(net_start), 32'(1));
    check("c1_ready_low", 32'(strm.s_ready), 32'(0));
    @(posedge clk); #1;
    check("c1_start_drop", 32'(net_start), 32'(0));
    check("c1_busy", 32'(frame_busy), 32'(1));
    check("c1_count", 32'(frame_count), 32'(1));
    check("c1_handshakes", 32'(hs_cnt - hs0), 32'(FrameBytes));
    check("c1_starts", 32'(st_cnt - st0), 32'(1));
    read_pix(10'd5, d);   check("c1_rd5", 32'(d), 32'h0005);
    read_pix(10'd783, d); check("c1_rd783", 32'(d), 32'h030F);
    read_pix(10'd800, d); check("c1_rd_oob", 32'(d), 32'h0000);
    check_frame("c1_pixel");

    // Case 3 (first half): held off while the network is busy.
    hs0 = hs_cnt; st0 = st_cnt;
    strm.s_valid = 1'b1;
    strm.s_data  = 8'h55;
    repeat (1000) begin @(posedge clk); #1; end
    check("c3_no_accept", 32'(hs_cnt - hs0), 32'(0));
    check("c3_busy", 32'(frame_busy), 32'(1));
    check("c3_ready", 32'(strm.s_ready), 32'(0));
    check("c3_no_restart", 32'(st_cnt - st0), 32'(0));
    net_done = 1'b1;
    @(posedge clk); #1;
    net_done     = 1'b0;
    strm.s_valid = 1'b0;
    check("c3_ready_after_done", 32'(strm.s_ready), 32'(1));
    check("c3_busy_clear", 32'(frame_busy), 32'(0));

    // Case 2: same frame with random gaps; second frame started.
    hs0 = hs_cnt; st0 = st_cnt;
    send_frame(0, 1'b1, 1'b0);
    check("c2_net_start", 32'(net_start), 32'(1));
    repeat (5) begin @(posedge clk); #1; end
    check("c2_ready_low", 32'(strm.s_ready), 32'(0));
    check("c2_handshakes", 32'(hs_cnt - hs0), 32'(FrameBytes));
    check("c2_starts", 32'(st_cnt - st0), 32'(1));
    check("c2_count", 32'(frame_count), 32'(2));
    check_frame("c2_pixel");
    pulse_net_done();

    // Case 6: read/write collision on pixel 0.
    pulse_rst();
    check("c6_count_rst", 32'(frame_count), 32'(0));
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    pulse_rst();
    rd_addr = 10'd0;
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    check("c6_old_data", 32'(rd_data), 32'h1111);
    @(posedge clk); #1;
    check("c6_new_data", 32'(rd_data), 32'h2222);

    // Case 4: reset mid-frame discards the partial frame.
    pulse_rst();
    st0 = st_cnt;
    for (int i = 0; i < 700; i++) send_byte(8'(i), 0);
    pulse_rst();
    check("c4_no_start", 32'(st_cnt - st0), 32'(0));
    send_frame(1, 1'b0, 1'b0);
    check("c4_net_start", 32'(net_start), 32'(1));
    @(posedge clk); #1;
    check("c4_starts", 32'(st_cnt - st0), 32'(1));
    check("c4_count", 32'(frame_count), 32'(1));
    check_frame("c4_pixel");
    pulse_net_done();

`ifdef FRAME_CHECKSUM_EN
    // Case 5: checksum good / bad / good.
    st0 = st_cnt;
    send_frame(0, 1'b0, 1'b0);
    check("c5_good_start", 32'(net_start), 32'(1));
    @(posedge clk); #1;
    check("c5_count2", 32'(frame_count), 32'(2));
    pulse_net_done();
    send_frame(0, 1'b0, 1'b1);
    check("c5_bad_no_start", 32'(net_start), 32'(0));
    check("c5_err", 32'(cksum_err), 32'(1));
    repeat (3) begin @(posedge clk); #1; end
    check("c5_bad_starts", 32'(st_cnt - st0), 32'(1));
    check("c5_count_hold", 32'(frame_count), 32'(2));
    check("c5_ready", 32'(strm.s_ready), 32'(1));
    send_frame(0, 1'b0, 1'b0);
    check("c5_recover_start", 32'(net_start), 32'(1));
    @(posedge clk); #1;
    check("c5_count3", 32'(frame_count), 32'(3));
    check("c5_err_sticky", 32'(cksum_err), 32'(1));
    exp_q.delete();
    pulse_net_done();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
